// File: rtl/mesh_port_wormhole_allocator_if.sv
// Link-side bundle between the input directions and one output-port allocator.
// The allocator is the slave; the router fabric (or a bench) is the master.
interface mesh_port_wormhole_allocator_if #(
  parameter int inputs_p    = 5,
  parameter int width_p     = 12,
  parameter int len_width_p = 2,
  parameter int credits_p   = 2
);
  localparam int cred_w_lp = $clog2(credits_p + 1);

  logic [inputs_p-1:0]             v_i;
  logic [inputs_p*width_p-1:0]     data_i;
  logic [inputs_p*len_width_p-1:0] len_i;
  logic [inputs_p-1:0]             yumi_o;
  logic                            v_o;
  logic [width_p-1:0]              data_o;
  logic                            credit_i;
  logic [cred_w_lp-1:0]            credits_o;
  logic                            locked_o;

  modport slave (
    input  v_i, data_i, len_i, credit_i,
    output yumi_o, v_o, data_o, credits_o, locked_o
  );

  modport master (
    output v_i, data_i, len_i, credit_i,
    input  yumi_o, v_o, data_o, credits_o, locked_o
  );
endinterface

// File: rtl/mesh_port_wormhole_allocator.sv
// Output-port allocator for one mesh direction: round-robin among input sides,
// wormhole lock for multi-flit packets, credit-based flow control downstream.
//
// state  | meaning
// IDLE   | no packet in flight; any valid input may win the round-robin scan
// LOCKED | owner_q holds the link until remaining_q more flits have been sent
module mesh_port_wormhole_allocator #(
  parameter int inputs_p    = 5,
  parameter int width_p     = 12,
  parameter int len_width_p = 2,
  parameter int credits_p   = 2
) (
  input logic clk_i,
  input logic reset_i,
  mesh_port_wormhole_allocator_if.slave bus
);
  localparam int ptr_w_lp = (inputs_p > 1) ? $clog2(inputs_p) : 1;
  localparam int cred_w_lp = $clog2(credits_p + 1);
  localparam logic [cred_w_lp-1:0] credits_max_lp = cred_w_lp'(credits_p);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                 state_q;
  logic [ptr_w_lp-1:0]    rr_ptr_q;
  logic [ptr_w_lp-1:0]    owner_q;
  logic [len_width_p-1:0] remaining_q;
  logic [cred_w_lp-1:0]   credits_q;

  logic                   found;
  logic                   send;
  logic [ptr_w_lp-1:0]    cand;
  logic [ptr_w_lp-1:0]    winner;
  logic [ptr_w_lp-1:0]    sel;
  logic [len_width_p-1:0] winner_len;

  function automatic logic [ptr_w_lp-1:0] inc_ptr(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(inputs_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // Round-robin scan: first valid input at or above rr_ptr_q, wrapping to 0.
  always_comb begin
    found      = 1'b0;
    winner     = '0;
    cand       = '0;
    winner_len = '0;
    for (int i = 0; i < inputs_p; i++) begin
      cand = ptr_w_lp'((int'(rr_ptr_q) + i) % inputs_p);
      if (!found && bus.v_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    for (int i = 0; i < inputs_p; i++) begin
      if (winner == ptr_w_lp'(i)) winner_len = bus.len_i[i*len_width_p +: len_width_p];
    end
  end

  // Grant and flit mux; a registered credit is required, and reset blocks all sends.
  always_comb begin
    sel        = (state_q == LOCKED) ? owner_q : winner;
    send       = 1'b0;
    bus.yumi_o = '0;
    bus.data_o = '0;
    if (!reset_i && credits_q != '0) begin
      send = (state_q == LOCKED) ? bus.v_i[owner_q] : found;
    end
    for (int i = 0; i < inputs_p; i++) begin
      bus.yumi_o[i] = send && (sel == ptr_w_lp'(i));
      if (bus.yumi_o[i]) bus.data_o = bus.data_i[i*width_p +: width_p];
    end
    bus.v_o       = send;
    bus.locked_o  = !reset_i && (state_q == LOCKED);
    bus.credits_o = reset_i ? credits_max_lp : credits_q;
  end

  // FSM, round-robin pointer and credit counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      remaining_q <= '0;
      credits_q   <= credits_max_lp;
    end else begin
      // A returned credit saturates at the FIFO depth rather than wrapping.
      if (send && !bus.credit_i) begin
        credits_q <= credits_q - cred_w_lp'(1);
      end else if (!send && bus.credit_i && credits_q != credits_max_lp) begin
        credits_q <= credits_q + cred_w_lp'(1);
      end
      case (state_q)
        IDLE: begin
          if (send) begin
            if (winner_len == '0) begin
              rr_ptr_q <= inc_ptr(winner);
            end else begin
              state_q     <= LOCKED;
              owner_q     <= winner;
              remaining_q <= winner_len;
            end
          end
        end
        LOCKED: begin
          if (send) begin
            remaining_q <= remaining_q - len_width_p'(1);
            if (remaining_q == len_width_p'(1)) begin
              state_q  <= IDLE;
              rr_ptr_q <= inc_ptr(owner_q);
            end
          end
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Downstream returned more credits than the FIFO has entries.
  credit_overflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(bus.credit_i && !send && credits_q == credits_max_lp));
`endif
endmodule

// File: tb/tb_mesh_port_wormhole_allocator.sv
// Directed bench for the wormhole allocator: each driven cycle queues its
// expected outputs; a negedge monitor pops and compares them.
module tb_mesh_port_wormhole_allocator;
  localparam int N = 5;
  localparam int W = 12;
  localparam int L = 2;
  localparam int C = 2;

  logic clk = 1'b0;
  logic rst;

  // 10-unit clock.
  always #5 clk = ~clk;

  mesh_port_wormhole_allocator_if #(.inputs_p(N), .width_p(W), .len_width_p(L), .credits_p(C)) bus();

  mesh_port_wormhole_allocator #(.inputs_p(N), .width_p(W), .len_width_p(L), .credits_p(C)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  logic [W-1:0] dat  [N];
  logic [L-1:0] lens [N];

  // Pack per-input flit and length arrays onto the flat buses.
  always_comb begin
    bus.data_i = '0;
    bus.len_i  = '0;
    for (int i = 0; i < N; i++) begin
      bus.data_i[i*W +: W] = dat[i];
      bus.len_i[i*L +: L]  = lens[i];
    end
  end

  typedef struct {
    logic         v;
    logic [N-1:0] yumi;
    logic [W-1:0] data;
    logic [1:0]   cred;
    logic         locked;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cr_m  = C;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare every queued expectation against the DUT outputs.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("v_o", 32'(bus.v_o), 32'(e.v));
      check("yumi_o", 32'(bus.yumi_o), 32'(e.yumi));
      if (e.v) check("data_o", 32'(bus.data_o), 32'(e.data));
      check("credits_o", 32'(bus.credits_o), 32'(e.cred));
      check("locked_o", 32'(bus.locked_o), 32'(e.locked));
    end else if (bus.v_o === 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_send: v_o=1 yumi_o=%0h with nothing expected", bus.yumi_o);
    end
  end

  // One cycle of stimulus plus its hand-computed expectation.
  task automatic cyc(input logic [N-1:0] v, input logic cr, input logic r,
                     input logic ev, input int eidx, input logic el);
    exp_t e;
    @(posedge clk);
    #1;
    bus.v_i      = v;
    bus.credit_i = cr;
    rst          = r;
    e.v      = ev;
    e.yumi   = ev ? (N'(1) << eidx) : '0;
    e.data   = ev ? dat[eidx] : '0;
    e.cred   = r ? 2'(C) : 2'(cr_m);
    e.locked = el;
    sb.push_back(e);
    cr_m = r ? C : cr_m + int'(cr) - int'(ev);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    bus.v_i      = '0;
    bus.credit_i = 1'b0;
    dat[0] = 12'h0F1; dat[1] = 12'h1E2; dat[2] = 12'h2D3; dat[3] = 12'h3C4; dat[4] = 12'h4B5;
    for (int i = 0; i < N; i++) lens[i] = '0;

    // Reset.
    cyc(5'b00000, 0, 1, 0, 0, 0);
    cyc(5'b00000, 0, 1, 0, 0, 0);

    // Single-flit fairness with credits looped back.
    cyc(5'b11111, 0, 0, 1, 0, 0);
    cyc(5'b11111, 1, 0, 1, 1, 0);
    cyc(5'b11111, 1, 0, 1, 2, 0);
    cyc(5'b11111, 1, 0, 1, 3, 0);
    cyc(5'b11111, 1, 0, 1, 4, 0);
    cyc(5'b11111, 1, 0, 1, 0, 0);
    cyc(5'b00000, 1, 0, 0, 0, 0);

    // Wormhole lock: input 2, len 3, inputs 0 and 4 waiting (rr_ptr=1).
    lens[2] = 2'd3;
    cyc(5'b10101, 0, 0, 1, 2, 0);
    cyc(5'b10101, 1, 0, 1, 2, 1);
    cyc(5'b10101, 1, 0, 1, 2, 1);
    cyc(5'b10101, 1, 0, 1, 2, 1);
    cyc(5'b10101, 1, 0, 1, 4, 0);
    cyc(5'b00000, 1, 0, 0, 0, 0);
    lens[2] = 2'd0;

    // Credit exhaustion, then one credit gives one flit.
    cyc(5'b00010, 0, 0, 1, 1, 0);
    cyc(5'b00010, 0, 0, 1, 1, 0);
    cyc(5'b00010, 0, 0, 0, 0, 0);
    cyc(5'b00010, 0, 0, 0, 0, 0);
    cyc(5'b00010, 1, 0, 0, 0, 0);
    cyc(5'b00010, 0, 0, 1, 1, 0);
    cyc(5'b00010, 0, 0, 0, 0, 0);

    // Simultaneous send and credit at credits=1.
    cyc(5'b00000, 1, 0, 0, 0, 0);
    cyc(5'b00010, 1, 0, 1, 1, 0);
    cyc(5'b00010, 0, 0, 1, 1, 0);
    cyc(5'b00000, 1, 0, 0, 0, 0);
    cyc(5'b00000, 1, 0, 0, 0, 0);

    // Owner bubble: input 3 locked with remaining=2, input 0 waiting.
    lens[3] = 2'd2;
    cyc(5'b01001, 0, 0, 1, 3, 0);
    cyc(5'b00001, 1, 0, 0, 0, 1);
    cyc(5'b00001, 0, 0, 0, 0, 1);
    cyc(5'b00001, 0, 0, 0, 0, 1);
    cyc(5'b01001, 0, 0, 1, 3, 1);
    cyc(5'b01001, 1, 0, 1, 3, 1);
    cyc(5'b00001, 1, 0, 1, 0, 0);
    cyc(5'b00000, 1, 0, 0, 0, 0);
    lens[3] = 2'd0;

    // Mid-packet reset: input 4 locked, remaining=2, credits=0.
    lens[4] = 2'd3;
    cyc(5'b10000, 0, 0, 1, 4, 0);
    cyc(5'b10000, 0, 0, 1, 4, 1);
    cyc(5'b10110, 0, 1, 0, 0, 0);
    cyc(5'b10110, 0, 0, 1, 1, 0);
    cyc(5'b00000, 1, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
